// File: rtl/seg_mem_arbiter.sv
// Round-robin arbiter: one fixed-latency access at a time to a shared 64 KiB single-port memory.
// Optional per-segment write protect is compiled in with `define SEG_WRITE_PROTECT_EN.
module seg_mem_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     req_we,
  input  logic [16*NREQ-1:0]  req_addr,
  input  logic [7:0]          wp_mask,
  output logic [NREQ-1:0]     ack,
  output logic [NREQ-1:0]     err,
  output logic                mem_en,
  output logic                mem_we,
  output logic [15:0]         mem_addr,
  output logic [2:0]          mem_seg,
  output logic                busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(LAT + 1);
  localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gnt_q, gnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [15:0]     addr_q, addr_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] err_q, err_d;

  logic            found;
  logic [PW-1:0]   pick;
  logic [PW:0]     sum;
  logic [15:0]     pick_addr;
  logic            reject;

  // Scan from ptr upward, wrapping modulo NREQ; first requester found wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      if (!found && req[sum[PW-1:0]]) begin
        found = 1'b1;
        pick  = sum[PW-1:0];
      end
    end
  end

  assign pick_addr = req_addr[{pick, 4'b0000} +: 16];

`ifdef SEG_WRITE_PROTECT_EN
  assign reject = req_we[pick] && wp_mask[pick_addr[15:13]];
`else
  logic wp_unused;
  assign wp_unused = ^wp_mask;
  assign reject    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    mem_en_d = mem_en_q;
    mem_we_d = mem_we_q;
    addr_d   = addr_q;
    ack_d    = '0;
    err_d    = '0;
    case (state_q)
      IDLE: if (found) begin
        gnt_d = pick;
        if (reject) begin
          state_d     = DONE;
          err_d[pick] = 1'b1;
        end else begin
          state_d  = ACCESS;
          mem_en_d = 1'b1;
          mem_we_d = req_we[pick];
          addr_d   = pick_addr;
          cnt_d    = CW'(LAT);
        end
      end
      ACCESS: begin
        if (cnt_q == CW'(1)) begin
          state_d      = DONE;
          mem_en_d     = 1'b0;
          ack_d[gnt_q] = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = (gnt_q == PW'(NREQ-1)) ? '0 : gnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      cnt_q    <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      addr_q   <= '0;
      ack_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
      addr_q   <= addr_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign mem_en   = mem_en_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = addr_q;
  assign mem_seg  = addr_q[15:13];
  assign busy     = (state_q != IDLE);

endmodule

// File: doc/seg_mem_arbiter.md
# seg_mem_arbiter

Round-robin arbiter sharing one single-port 64 KiB memory between NREQ requesters. Each request carries a 16-bit address and a read/write flag. The arbiter sequences one fixed-latency memory access at a time and drives the memory enable, address and 3-bit segment number (addr[15:13], 8 segments of 8 KiB). An optional per-segment write-protect check rejects writes before they reach memory.

## Interface
- NREQ, 4: number of requesters, 2..8
- LAT, 2: memory access cycles with mem_en held high, >=1
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request level; held until ack/err
- req_we  in  NREQ  1 = write, 0 = read; held with req
- req_addr  in  16*NREQ  packed; requester i at [16*i+15:16*i]; held with req
- wp_mask  in  8  per-segment write protect; bit s protects segment s
- ack  out  NREQ  one-cycle completion pulse, one-hot
- err  out  NREQ  one-cycle rejection pulse, one-hot
- mem_en  out  1  memory access strobe
- mem_we  out  1  write qualifier, valid while mem_en
- mem_addr  out  16  access address, valid while mem_en
- mem_seg  out  3  mem_addr[15:13], always equal to it
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if any req bit is high, grant the first requester at or above the rotation pointer `ptr`, wrapping modulo NREQ. Latch the grant index, req_we and req_addr of that requester. Go to ACCESS, or go to DONE-with-error if the access is rejected (see Configuration). With no requests, stay in IDLE.
- ACCESS: mem_en=1 with the latched mem_we, mem_addr and mem_seg. A down-counter of width $clog2(LAT+1) is loaded with LAT on entry. Leave for DONE when the counter reaches the last cycle.
- DONE: exactly one of ack[g] or err[g] is high for one cycle, where g is the granted index. ptr <= (g+1) mod NREQ. Go to IDLE. req is ignored in DONE.
- A requester must drop req, or present a new request, on the edge ending its ack/err cycle. A request still held is treated as a new request.
- Changes to req, req_addr or req_we of a non-granted requester never disturb an access in flight. The latched copies are used.
- Reset values: state IDLE, ptr 0, ack 0, err 0, mem_en 0, mem_we 0, mem_addr 0, mem_seg 0, busy 0.
- Reset mid-access: all outputs go to reset values immediately (asynchronous). The abandoned access produces no ack or err.

## Timing
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- A request sampled in IDLE at edge n gives: mem_en high in cycles n+1..n+LAT, then ack high in cycle n+LAT+1.
- A rejected request sampled at edge n gives err high in cycle n+1, with no mem_en.
- Back-to-back throughput is one access per LAT+2 cycles. IDLE always lasts at least one cycle between accesses.
- Fairness: a continuously requesting requester is granted within NREQ-1 other grants.

## Configuration
- SEG_WRITE_PROTECT_EN defined:
  - In IDLE, a granted write whose req_addr[15:13] selects a set wp_mask bit is rejected. The arbiter goes directly to DONE, pulses err[g], never asserts mem_en, and still advances ptr.
  - Reads are never rejected.
  - wp_mask is sampled only in the grant cycle.
- SEG_WRITE_PROTECT_EN undefined:
  - wp_mask is ignored and err is tied to 0.
  - Every access goes through ACCESS and ends with ack.

## Test plan
- Reset: hold rst_n=0 with req=4'hF -> all outputs 0. Then assert rst_n=0 in the middle of ACCESS -> mem_en drops in the same cycle and no ack follows.
- Single read, NREQ=4, LAT=2: req[0]=1, addr 16'h2345, sampled at edge n -> mem_en=1, mem_addr=16'h2345, mem_seg=3'd1 in cycles n+1 and n+2; ack=4'b0001 in n+3 only.
- Contention: req=4'hF held from reset, each requester dropping req on its ack -> ack order 0,1,2,3 at 4-cycle spacing. Then re-raise req[0] and req[2] together -> 0 is granted first (ptr wrapped to 0). A further repeat with ptr=1 grants 2 before 0.
- Write protect with macro defined: wp_mask=8'h80, requester 1 writes 16'hE000 -> err=4'b0010 one cycle after sampling, mem_en stays 0. The same address as a read -> normal ack[1] after LAT+1 cycles.
- Same write with the macro undefined -> mem_en=1 and mem_we=1 for 2 cycles, then ack=4'b0010; err stays 0.
- Wrap and segment boundary: addresses 16'h1FFF and 16'h2000 from requester 3 -> mem_seg 0 then 1. The grant after requester 3 wraps to requester 0.
